// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU opcodes, operand-select encodings and CCR bit indices
package ex_pkg;
  localparam logic [3:0] ALU_PASS_B = 4'h0;
  localparam logic [3:0] ALU_ADD    = 4'h1;
  localparam logic [3:0] ALU_SUB    = 4'h2;
  localparam logic [3:0] ALU_AND    = 4'h3;
  localparam logic [3:0] ALU_OR     = 4'h4;
  localparam logic [3:0] ALU_XOR    = 4'h5;
  localparam logic [3:0] ALU_NOT    = 4'h6;
  localparam logic [3:0] ALU_INC    = 4'h7;
  localparam logic [3:0] ALU_DEC    = 4'h8;
  localparam logic [3:0] ALU_NEG    = 4'h9;
  localparam logic [3:0] ALU_SHL    = 4'hA;
  localparam logic [3:0] ALU_SHR    = 4'hB;
  localparam logic [3:0] ALU_RLC    = 4'hC;
  localparam logic [3:0] ALU_RRC    = 4'hD;
  localparam logic [3:0] ALU_SETC   = 4'hE;
  localparam logic [3:0] ALU_CLRC   = 4'hF;
  localparam logic [1:0] OP2_B    = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_PC   = 2'd2;
  localparam logic [1:0] OP2_ZERO = 2'd3;
  localparam logic [1:0] FWD_ID  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/ex_stage_alu8.sv
// alu8: combinational ALU producing result, next flag values and per-flag update enables
module alu8 import ex_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             z_en,
  output logic             n_en,
  output logic             c_en,
  output logic             v_en
);
  localparam int M = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
  logic [WIDTH:0] ext;
  assign z = ~|result;
  assign n = result[M];
  // Arithmetic runs at WIDTH+1 bits so bit WIDTH is carry out or borrow.
  always_comb begin
    ext = '0;
    result = b;
    c = c_in;
    v = 1'b0;
    c_en = 1'b0;
    z_en = 1'b1;
    n_en = 1'b1;
    v_en = 1'b1;
    case (alu_sel)
      ALU_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        result = ext[M:0];
        c = ext[WIDTH];
        c_en = 1'b1;
        v = (a[M] == b[M]) && (result[M] != a[M]);
      end
      ALU_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        result = ext[M:0];
        c = ext[WIDTH];
        c_en = 1'b1;
        v = (a[M] != b[M]) && (result[M] != a[M]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_INC: begin
        ext = {1'b0, a} + ONE;
        result = ext[M:0];
        c = ext[WIDTH];
        c_en = 1'b1;
        v = !a[M] && result[M];
      end
      ALU_DEC: begin
        ext = {1'b0, a} - ONE;
        result = ext[M:0];
        c = ext[WIDTH];
        c_en = 1'b1;
        v = a[M] && !result[M];
      end
      ALU_NEG: begin
        ext = '0 - {1'b0, a};
        result = ext[M:0];
        c = ext[WIDTH];
        c_en = 1'b1;
        v = a[M] && result[M];
      end
      ALU_SHL: begin
        result = {a[M-1:0], 1'b0};
        c = a[M];
        c_en = 1'b1;
      end
      ALU_SHR: begin
        result = {1'b0, a[M:1]};
        c = a[0];
        c_en = 1'b1;
      end
      ALU_RLC: begin
        result = {a[M-1:0], c_in};
        c = a[M];
        c_en = 1'b1;
      end
      ALU_RRC: begin
        result = {c_in, a[M:1]};
        c = a[0];
        c_en = 1'b1;
      end
      ALU_SETC, ALU_CLRC: begin
        c = (alu_sel == ALU_SETC);
        c_en = 1'b1;
        z_en = 1'b0;
        n_en = 1'b0;
        v_en = 1'b0;
      end
      default: result = b;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand forwarding, ALU, condition-code register and EX/MEM pipeline register
module ex_stage import ex_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             flush,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             flag_en,
  input  logic [1:0]       dst_reg,
  input  logic [3:0]       alu_sel,
  input  logic [1:0]       op2_sel,
  input  logic [1:0]       wb_sel,
  input  logic [WIDTH-1:0] ra_val,
  input  logic [WIDTH-1:0] rb_val,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] mem_fwd_val,
  input  logic [WIDTH-1:0] wb_fwd_val,
  input  logic             flags_ld,
  input  logic [3:0]       flags_ld_val,
  output logic             reg_write_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [1:0]       dst_reg_out,
  output logic [1:0]       wb_sel_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] store_data_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [3:0]       flags_out
);
  logic [WIDTH-1:0] op_a, fwd_b, op_b, result;
  logic z, n, c, v, z_en, n_en, c_en, v_en;
  logic [3:0] ccr_nxt;
  // Forwarding muxes; encoding 3 falls back to the ID/EX value.
  always_comb begin
    op_a = fwd_a_sel == FWD_MEM ? mem_fwd_val : fwd_a_sel == FWD_WB ? wb_fwd_val : ra_val;
    fwd_b = fwd_b_sel == FWD_MEM ? mem_fwd_val : fwd_b_sel == FWD_WB ? wb_fwd_val : rb_val;
    op_b = op2_sel == OP2_IMM ? imm : op2_sel == OP2_PC ? pc : op2_sel == OP2_ZERO ? '0 : fwd_b;
  end
  alu8 #(.WIDTH(WIDTH)) u_alu (
    .a(op_a), .b(op_b), .alu_sel(alu_sel), .c_in(flags_out[FLAG_C]),
    .result(result), .z(z), .n(n), .c(c), .v(v),
    .z_en(z_en), .n_en(n_en), .c_en(c_en), .v_en(v_en)
  );
  // Merge per-flag updates with the current CCR so untouched flags hold.
  always_comb begin
    ccr_nxt = flags_out;
    ccr_nxt[FLAG_Z] = z_en ? z : flags_out[FLAG_Z];
    ccr_nxt[FLAG_N] = n_en ? n : flags_out[FLAG_N];
    ccr_nxt[FLAG_C] = c_en ? c : flags_out[FLAG_C];
    ccr_nxt[FLAG_V] = v_en ? v : flags_out[FLAG_V];
  end
  // CCR: an explicit load beats stall and flush, so interrupt return always lands.
  always_ff @(posedge clk) begin
    if (rst) flags_out <= '0;
    else if (flags_ld) flags_out <= flags_ld_val;
    else if (!flush && wr_en && flag_en) flags_out <= ccr_nxt;
  end
  // EX/MEM register: flush inserts a bubble even while stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      reg_write_out <= 1'b0;
      mem_read_out <= 1'b0;
      mem_write_out <= 1'b0;
      dst_reg_out <= '0;
      wb_sel_out <= '0;
      alu_result_out <= '0;
      store_data_out <= '0;
      pc_out <= '0;
    end else if (wr_en) begin
      reg_write_out <= reg_write;
      mem_read_out <= mem_read;
      mem_write_out <= mem_write;
      dst_reg_out <= dst_reg;
      wb_sel_out <= wb_sel;
      alu_result_out <= result;
      store_data_out <= fwd_b;
      pc_out <= pc;
    end
  end
endmodule
